// File: rtl/lcd_rgb_timing_gen.sv
// lcd_rgb_timing_gen: RGB-parallel LCD timing generator with frame-request handshake.
//   Generates HSYNC/VSYNC/DE from free-running h/v counters, pulls RGB565 pixels
//   from a 1-cycle-latency line FIFO and drives 8:8:8 pins through an aligned
//   2-stage pipeline (every pin lags the counters by exactly 2 clocks).
// Ports:
//   CLK, RST (async, active high)      clock and reset
//   FRAME_REQ                          level request; sampled at frame boundaries
//   FIFO_Empty, FIFO_Data[15:0]        FIFO status and RGB565 data (valid 1 clk after FIFO_RE)
//   FIFO_RE, FIFO_RST                  FIFO read enable and per-frame reset pulse
//   LCD_HSYNC, LCD_VSYNC, LCD_DE       panel timing, polarities from HS_POL/VS_POL/DE_POL
//   LCD_R, LCD_G, LCD_B [7:0]          panel colour
//   BUSY, FRAME_DONE, UNDERFLOW        status: running, last frame clock, sticky starvation
// Optional: LCD_TEST_PATTERN_EN adds PATTERN_SEL selecting 8 vertical colour bars.
module lcd_rgb_timing_gen #(
  parameter int          H_ACTIVE      = 480,
  parameter int          H_FP          = 8,
  parameter int          H_SYNC        = 4,
  parameter int          H_BP          = 43,
  parameter int          V_ACTIVE      = 272,
  parameter int          V_FP          = 8,
  parameter int          V_SYNC        = 4,
  parameter int          V_BP          = 12,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter bit          DE_POL        = 1'b1,
  parameter int          CNT_W         = 12,
  parameter int          FIFO_RST_CYC  = 10,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME_REQ,
`ifdef LCD_TEST_PATTERN_EN
  input  logic        PATTERN_SEL,
`endif
  input  logic        FIFO_Empty,
  input  logic [15:0] FIFO_Data,
  output logic        FIFO_RE,
  output logic        FIFO_RST,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        LCD_DE,
  output logic [7:0]  LCD_R,
  output logic [7:0]  LCD_G,
  output logic [7:0]  LCD_B,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        UNDERFLOW
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_AS   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_AE   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_AS   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_AE   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] RST_E  = CNT_W'(FIFO_RST_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             run, h_last, frame_last, act, start, pat;
  logic             hs1_q, vs1_q, de1_q, re1_q, pat1_q;
  logic             hs2_q, vs2_q, de2_q, uf_q, uf_d;
  logic [23:0]      rgb2_q, rgb_d, pat_rgb;

  assign run        = state_q == RUN;
  assign h_last     = h_q == H_LAST;
  assign frame_last = run && h_last && v_q == V_LAST;
  assign act        = run && h_q >= H_AS && h_q < H_AE && v_q >= V_AS && v_q < V_AE;
  // A new frame begins either from IDLE or by wrapping at the last clock of a frame.
  assign start      = FRAME_REQ && (!run || frame_last);

  always_comb begin
    state_d = ((run && !frame_last) || FRAME_REQ) ? RUN : IDLE;
    h_d     = (!run || h_last) ? '0 : h_q + ONE;
    v_d     = (!run || frame_last) ? '0 : h_last ? v_q + ONE : v_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [CNT_W-1:0] bar_idx;
  logic [2:0]       bar_d, bar1_q;
  assign pat     = PATTERN_SEL;
  assign bar_idx = (h_q - H_AS) / CNT_W'(BAR_W);
  assign bar_d   = (bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0];
  // Bar index bits 0/1/2 switch R/G/B fully on: black, red, green, yellow, blue, magenta, cyan, white.
  assign pat_rgb = {{8{bar1_q[0]}}, {8{bar1_q[1]}}, {8{bar1_q[2]}}};
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat1_q <= 1'b0;
      bar1_q <= '0;
    end else begin
      pat1_q <= pat;
      bar1_q <= bar_d;
    end
  end
`else
  assign pat     = 1'b0;
  assign pat1_q  = 1'b0;
  assign pat_rgb = '0;
`endif

  assign FIFO_RE = act && !FIFO_Empty && !pat;

  // Stage 1: timing and read flags; FIFO_Data for this pixel arrives during this stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de1_q <= 1'b0;
      re1_q <= 1'b0;
    end else begin
      hs1_q <= run && h_q < H_SE;
      vs1_q <= run && v_q < V_SE;
      de1_q <= act;
      re1_q <= FIFO_RE;
    end
  end

  always_comb begin
    rgb_d = !de1_q ? 24'h0 : pat1_q ? pat_rgb : re1_q ?
            {FIFO_Data[15:11], FIFO_Data[15:13], FIFO_Data[10:5], FIFO_Data[10:9],
             FIFO_Data[4:0], FIFO_Data[4:2]} : UNDERFLOW_RGB;
    uf_d  = start ? 1'b0 : uf_q | (de1_q & ~re1_q & ~pat1_q);
  end

  // Stage 2: panel pins; UNDERFLOW rises together with the first starved pixel on the pins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs2_q  <= ~HS_POL;
      vs2_q  <= ~VS_POL;
      de2_q  <= ~DE_POL;
      rgb2_q <= '0;
      uf_q   <= 1'b0;
    end else begin
      hs2_q  <= hs1_q ? HS_POL : ~HS_POL;
      vs2_q  <= vs1_q ? VS_POL : ~VS_POL;
      de2_q  <= de1_q ? DE_POL : ~DE_POL;
      rgb2_q <= rgb_d;
      uf_q   <= uf_d;
    end
  end

  assign FIFO_RST   = run && v_q == '0 && h_q < RST_E;
  assign BUSY       = run;
  assign FRAME_DONE = frame_last;
  assign UNDERFLOW  = uf_q;
  assign LCD_HSYNC  = hs2_q;
  assign LCD_VSYNC  = vs2_q;
  assign LCD_DE     = de2_q;
  assign LCD_R      = rgb2_q[23:16];
  assign LCD_G      = rgb2_q[15:8];
  assign LCD_B      = rgb2_q[7:0];
endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// tb_lcd_rgb_timing_gen: bench for lcd_rgb_timing_gen using a reduced panel geometry.
module tb_lcd_rgb_timing_gen;
  localparam int HA = 16, HF = 2, HS = 2, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FR = HT * VT;
  localparam int RC = 5;
  localparam int C_HS = 0, C_VS = 1, C_DE = 2, C_RED = 3, C_GFF = 4, C_WHT = 5;
  localparam int C_BLK = 6, C_DONE = 7, C_FRST = 8, C_BUSY = 9, C_RE = 10;
  localparam logic [26:0] IDLE_PIN = {1'b1, 1'b1, 1'b0, 24'h0};

  logic        CLK = 0, RST = 0, FRAME_REQ = 0, FIFO_Empty = 0, pat = 0;
  logic [15:0] FIFO_Data = 16'h0;
  logic        FIFO_RE, FIFO_RST, LCD_HSYNC, LCD_VSYNC, LCD_DE, BUSY, FRAME_DONE, UNDERFLOW;
  logic [7:0]  LCD_R, LCD_G, LCD_B;
  logic [31:0] dv;

  lcd_rgb_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_RST_CYC(RC)
  ) dut (
    .CLK(CLK), .RST(RST), .FRAME_REQ(FRAME_REQ),
`ifdef LCD_TEST_PATTERN_EN
    .PATTERN_SEL(pat),
`endif
    .FIFO_Empty(FIFO_Empty), .FIFO_Data(FIFO_Data), .FIFO_RE(FIFO_RE), .FIFO_RST(FIFO_RST),
    .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC), .LCD_DE(LCD_DE),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  assign dv = {FIFO_RE, FIFO_RST, BUSY, FRAME_DONE, UNDERFLOW, LCD_HSYNC, LCD_VSYNC, LCD_DE,
               LCD_R, LCD_G, LCD_B};

  int checks = 0, errors = 0, cyc = 0, mode = 0;
  bit chk_en = 0, emp_en = 0;
  int cnt [11];
  int snap [11];
  logic [23:0] bars [8] = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
                            24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF};

  // Frame model state: position inside the frame, pins for the last two counter slots.
  int mpos = 0, rd_mod = 0, rd_act = 0;
  bit mrun = 0, uf = 0, st1 = 0, re_s = 0;
  logic [26:0] p1 = IDLE_PIN, p2 = IDLE_PIN;

  function automatic logic [15:0] wd(input int m, input int k);
    int x;
    x = (k * 32'h3C5B) ^ 32'h1234;
    return (m == 0) ? 16'hF800 : (m == 1) ? 16'h07E0 : x[15:0];
  endfunction

  function automatic logic [23:0] ex565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // FIFO: a read seen in a cycle delivers the next word one clock later.
  always begin
    @(negedge CLK);
    re_s = FIFO_RE;
    @(posedge CLK);
    #1;
    if (re_s) begin
      FIFO_Data = wd(mode, rd_act);
      rd_act++;
    end
  end

  always @(negedge CLK) begin
    int h, v;
    bit act, ere, start;
    logic [26:0] cs;
    cyc++;
    if (chk_en) begin
      if (!LCD_HSYNC) cnt[C_HS]++;
      if (!LCD_VSYNC) cnt[C_VS]++;
      if (LCD_DE) cnt[C_DE]++;
      if (LCD_DE && {LCD_R, LCD_G, LCD_B} == 24'hFF0000) cnt[C_RED]++;
      if (LCD_DE && LCD_G == 8'hFF) cnt[C_GFF]++;
      if (LCD_DE && {LCD_R, LCD_G, LCD_B} == 24'hFFFFFF) cnt[C_WHT]++;
      if (LCD_DE && {LCD_R, LCD_G, LCD_B} == 24'h000000) cnt[C_BLK]++;
      if (FRAME_DONE) cnt[C_DONE]++;
      if (FIFO_RST) cnt[C_FRST]++;
      if (BUSY) cnt[C_BUSY]++;
      if (FIFO_RE) cnt[C_RE]++;
      if (RST) begin
        mrun = 0; mpos = 0; uf = 0; st1 = 0; p1 = IDLE_PIN; p2 = IDLE_PIN;
        check("reset_outputs", dv, {5'b0, IDLE_PIN});
      end else begin
        h = mpos % HT;
        v = mpos / HT;
        act = mrun && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
        ere = act && !FIFO_Empty && !pat;
        cs = {!(mrun && h < HS), !(mrun && v < VS), act,
              !act ? 24'h0 : pat ? bars[(h - HS - HB) / (HA / 8)] :
              ere ? ex565(wd(mode, rd_mod)) : 24'hFF0000};
        check("cycle_outputs", dv, {ere, mrun && v == 0 && h < RC, mrun, mrun && mpos == FR - 1, uf, p2});
        start = FRAME_REQ && (!mrun || mpos == FR - 1);
        uf = start ? 1'b0 : (uf | st1);
        p2 = p1;
        p1 = cs;
        st1 = act && !ere && !pat;
        if (ere) rd_mod++;
        if (mrun && mpos != FR - 1) mpos++;
        else begin
          mrun = FRAME_REQ;
          mpos = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    FIFO_Empty = emp_en && mrun && (mpos / HT == VS + VB + 2) &&
                 (mpos % HT >= HS + HB + 10) && (mpos % HT <= HS + HB + 13);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 2 * FR && !got; i++) begin
      tick();
      got = FRAME_DONE;
    end
    check("frame_done_seen", {31'b0, got}, 32'd1);
  endtask

  int c1, c2, c3;
  bit hit;

  initial begin
    foreach (cnt[i]) cnt[i] = 0;
    #2 RST = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    chk_en = 1;
    repeat (1000) tick();
    check("idle_busy", {31'b0, BUSY}, 0);
    check("idle_hsync", {31'b0, LCD_HSYNC}, 1);
    check("idle_vsync", {31'b0, LCD_VSYNC}, 1);
    check("idle_de", {31'b0, LCD_DE}, 0);
    check("idle_fifo_re", {31'b0, FIFO_RE}, 0);

    snap = cnt;
    FRAME_REQ = 1;
    tick();
    FRAME_REQ = 0;
    wait_done();
    repeat (5) tick();
    check("f1_hsync_low", cnt[C_HS] - snap[C_HS], HS * VT);
    check("f1_vsync_low", cnt[C_VS] - snap[C_VS], VS * HT);
    check("f1_de_pixels", cnt[C_DE] - snap[C_DE], HA * VA);
    check("f1_red_pixels", cnt[C_RED] - snap[C_RED], HA * VA);
    check("f1_done_count", cnt[C_DONE] - snap[C_DONE], 1);
    check("f1_busy_cycles", cnt[C_BUSY] - snap[C_BUSY], FR);
    check("f1_busy_after", {31'b0, BUSY}, 0);

    mode = 1;
    FRAME_REQ = 1;
    wait_done();
    c1 = cyc;
    snap = cnt;
    wait_done();
    c2 = cyc;
    wait_done();
    c3 = cyc;
    check("done_interval_a", c2 - c1, FR);
    check("done_interval_b", c3 - c2, FR);
    check("fifo_rst_cycles", cnt[C_FRST] - snap[C_FRST], 2 * RC);
    check("green_pixels", cnt[C_GFF] - snap[C_GFF], 2 * HA * VA);
    check("busy_no_gap", cnt[C_BUSY] - snap[C_BUSY], 2 * FR);

    snap = cnt;
    emp_en = 1;
    wait_done();
    check("uf_red_pixels", cnt[C_RED] - snap[C_RED], 4);
    check("uf_green_pixels", cnt[C_GFF] - snap[C_GFF], HA * VA - 4);
    check("uf_at_frame_end", {31'b0, UNDERFLOW}, 1);
    emp_en = 0;
    tick();
    check("uf_after_wrap", {31'b0, UNDERFLOW}, 0);

    mode = 2;
    repeat (100) tick();
    FRAME_REQ = 0;
    wait_done();
    repeat (5) tick();
    check("stop_busy", {31'b0, BUSY}, 0);

    mode = 1;
    FRAME_REQ = 1;
    hit = 0;
    for (int i = 0; i < 2 * FR && !hit; i++) begin
      tick();
      hit = BUSY && mpos == 7 * HT + 12;
    end
    check("reached_reset_point", {31'b0, hit}, 1);
    check("pre_reset_de", {31'b0, LCD_DE}, 1);
    #1 RST = 1;
    FRAME_REQ = 0;
    #1 check("async_reset_outputs", dv, {5'b0, 3'b110, 24'h0});
    @(posedge CLK);
    #1 RST = 0;
    snap = cnt;
    repeat (300) tick();
    check("post_reset_busy", cnt[C_BUSY] - snap[C_BUSY], 0);
    check("post_reset_de", cnt[C_DE] - snap[C_DE], 0);

`ifdef LCD_TEST_PATTERN_EN
    pat = 1;
    snap = cnt;
    FRAME_REQ = 1;
    tick();
    FRAME_REQ = 0;
    wait_done();
    repeat (5) tick();
    check("pat_no_reads", cnt[C_RE] - snap[C_RE], 0);
    check("pat_white", cnt[C_WHT] - snap[C_WHT], 2 * VA);
    check("pat_black", cnt[C_BLK] - snap[C_BLK], 2 * VA);
    check("pat_red", cnt[C_RED] - snap[C_RED], 2 * VA);
    check("pat_no_underflow", {31'b0, UNDERFLOW}, 0);
    pat = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
